// File: rtl/hs32_mpu_pkg.sv
// Shared types for the hs32 memory protection unit: access encodings, ATTR word
// layout, the region entry record and the region size clamp.
package hs32_mpu_pkg;

    typedef enum logic [1:0] {
        ACC_R    = 2'b00,
        ACC_W    = 2'b01,
        ACC_X    = 2'b10,
        ACC_NONE = 2'b11
    } acc_t;

    localparam int ATTR_EN      = 0;
    localparam int ATTR_LOCK    = 1;
    localparam int ATTR_PERM_LO = 2;
    localparam int ATTR_SIZE_LO = 6;
    localparam int ATTR_SRD_LO  = 16;
    localparam int ATTR_TAG_LO  = 24;

    // size is 6 bits so a full 4 GiB region (size 32) stays representable in the matcher
    typedef struct packed {
        logic [31:0] base;
        logic        en;
        logic        lock;
        logic [2:0]  perm;    // {X, W, R}
        logic [5:0]  size;
        logic [7:0]  srd;
        logic [7:0]  tag;
    } region_t;

    function automatic logic [5:0] clamp_size(input logic [4:0] raw, input int min_sz);
        if (int'(raw) < min_sz) begin
            return 6'(min_sz);
        end
        return {1'b0, raw};
    endfunction

endpackage

// File: rtl/hs32_mpu_match.sv
// Combinational comparator for one region entry: range, tag and subregion match,
// plus the permission bit for the requested access type.
module hs32_mpu_match
    import hs32_mpu_pkg::*;
#(
    parameter int NUM_SUBRGN = 8,
    parameter int TAG_W      = 3
) (
    input  region_t          rgn,
    input  logic [31:0]      addr,
    input  logic [TAG_W-1:0] tag,
    input  logic [1:0]       acc,
    output logic             hit,
    output logic             allow
);

    localparam int SUB_BITS = $clog2(NUM_SUBRGN);

    logic       in_range;
    logic [2:0] sub_idx;
    logic       unused_lock;

    assign unused_lock = rgn.lock;

    always_comb begin
        in_range = (((addr ^ rgn.base) >> rgn.size) == 32'd0);
        // subregion index is the top SUB_BITS bits below the region size
        sub_idx  = 3'((addr >> (rgn.size - 6'(SUB_BITS))) & 32'(NUM_SUBRGN - 1));
        hit      = rgn.en && (rgn.tag == 8'(tag)) && in_range && rgn.srd[sub_idx];
        case (acc_t'(acc))
            ACC_R:   allow = rgn.perm[0];
            ACC_W:   allow = rgn.perm[1];
            ACC_X:   allow = rgn.perm[2];
            default: allow = 1'b0;
        endcase
    end

endmodule

// File: rtl/hs32_mpu_pipe.sv
// Pipelined MPU: region table with CSR port, priority pick across per-region
// comparators, 1-cycle registered valid/ready response and sticky first-fault capture.
module hs32_mpu_pipe
    import hs32_mpu_pkg::*;
#(
    parameter int NUM_REGNS     = 8,
    parameter int NUM_SUBRGN    = 8,
    parameter int TAG_W         = 3,
    parameter int MIN_SZ        = 5,
    parameter bit DEFAULT_ALLOW = 1'b0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_REGNS)-1:0] cfg_idx,
    input  logic                         cfg_sel,
    input  logic [31:0]                  cfg_wdata,
    output logic [31:0]                  cfg_rdata,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [31:0]                  req_addr,
    input  logic [TAG_W-1:0]             req_tag,
    input  logic [1:0]                   req_acc,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_ok,
    output logic                         rsp_hit,
    output logic [$clog2(NUM_REGNS)-1:0] rsp_rgn,
    output logic                         fault_valid,
    output logic [31:0]                  fault_addr,
    output logic [1:0]                   fault_acc,
    output logic [TAG_W-1:0]             fault_tag,
    input  logic                         fault_clr
);

    localparam int         IDX_W    = $clog2(NUM_REGNS);
    localparam logic [7:0] SRD_MASK = 8'((1 << NUM_SUBRGN) - 1);
    localparam logic [7:0] TAG_MASK = 8'((1 << TAG_W) - 1);

    region_t rgn_q [NUM_REGNS];
    region_t rgn_d [NUM_REGNS];
    region_t rd_rgn;

    logic [NUM_REGNS-1:0] hit_vec;
    logic [NUM_REGNS-1:0] allow_vec;
    logic                 win_hit;
    logic                 win_ok;
    logic [IDX_W-1:0]     win_rgn;
    logic                 accept;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_ok_q, rsp_ok_d;
    logic             rsp_hit_q, rsp_hit_d;
    logic [IDX_W-1:0] rsp_rgn_q, rsp_rgn_d;
    logic             fault_valid_q, fault_valid_d;
    logic [31:0]      fault_addr_q, fault_addr_d;
    logic [1:0]       fault_acc_q, fault_acc_d;
    logic [TAG_W-1:0] fault_tag_q, fault_tag_d;

    logic [6:0] unused_bits;
    assign unused_bits = {cfg_wdata[15:11], cfg_wdata[5], rd_rgn.size[5]};

    always_comb begin
        for (int i = 0; i < NUM_REGNS; i++) begin
            rgn_d[i] = rgn_q[i];
            if (cfg_we && (cfg_idx == IDX_W'(i)) && !rgn_q[i].lock) begin
                if (cfg_sel) begin
                    rgn_d[i].en   = cfg_wdata[ATTR_EN];
                    rgn_d[i].lock = cfg_wdata[ATTR_LOCK];
                    rgn_d[i].perm = cfg_wdata[ATTR_PERM_LO +: 3];
                    rgn_d[i].size = clamp_size(cfg_wdata[ATTR_SIZE_LO +: 5], MIN_SZ);
                    rgn_d[i].srd  = cfg_wdata[ATTR_SRD_LO +: 8] & SRD_MASK;
                    rgn_d[i].tag  = cfg_wdata[ATTR_TAG_LO +: 8] & TAG_MASK;
                end else begin
                    rgn_d[i].base = cfg_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGNS; i++) begin
                rgn_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGNS; i++) begin
                rgn_q[i] <= rgn_d[i];
            end
        end
    end

    always_comb begin
        rd_rgn    = rgn_q[cfg_idx];
        cfg_rdata = rd_rgn.base;
        if (cfg_sel) begin
            cfg_rdata = {rd_rgn.tag, rd_rgn.srd, 5'b0, rd_rgn.size[4:0], 1'b0,
                         rd_rgn.perm, rd_rgn.lock, rd_rgn.en};
        end
    end

    for (genvar gi = 0; gi < NUM_REGNS; gi++) begin : g_match
        hs32_mpu_match #(
            .NUM_SUBRGN (NUM_SUBRGN),
            .TAG_W      (TAG_W)
        ) u_match (
            .rgn   (rgn_q[gi]),
            .addr  (req_addr),
            .tag   (req_tag),
            .acc   (req_acc),
            .hit   (hit_vec[gi]),
            .allow (allow_vec[gi])
        );
    end

    // Scan from the top down so the lowest matching index overwrites the rest
    always_comb begin
        win_hit = 1'b0;
        win_rgn = '0;
        win_ok  = DEFAULT_ALLOW && (req_acc != ACC_NONE);
        for (int i = NUM_REGNS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_hit = 1'b1;
                win_rgn = IDX_W'(i);
                win_ok  = allow_vec[i];
            end
        end
    end

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_ok_d      = rsp_ok_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_rgn_d     = rsp_rgn_q;
        fault_valid_d = fault_valid_q && !fault_clr;
        fault_addr_d  = fault_addr_q;
        fault_acc_d   = fault_acc_q;
        fault_tag_d   = fault_tag_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_ok_d    = win_ok;
            rsp_hit_d   = win_hit;
            rsp_rgn_d   = win_rgn;
            if (!win_ok && !fault_valid_d) begin
                fault_valid_d = 1'b1;
                fault_addr_d  = req_addr;
                fault_acc_d   = req_acc;
                fault_tag_d   = req_tag;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_q   <= 1'b0;
            rsp_ok_q      <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_rgn_q     <= '0;
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
            fault_acc_q   <= '0;
            fault_tag_q   <= '0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_ok_q      <= rsp_ok_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_rgn_q     <= rsp_rgn_d;
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
            fault_acc_q   <= fault_acc_d;
            fault_tag_q   <= fault_tag_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_ok      = rsp_ok_q;
    assign rsp_hit     = rsp_hit_q;
    assign rsp_rgn     = rsp_rgn_q;
    assign fault_valid = fault_valid_q;
    assign fault_addr  = fault_addr_q;
    assign fault_acc   = fault_acc_q;
    assign fault_tag   = fault_tag_q;

endmodule

// File: tb/tb_hs32_mpu_pipe.sv
// Directed bench for hs32_mpu_pipe: table programming, subregions, priority,
// locking, async reset, backpressure and first-fault capture.
module tb_hs32_mpu_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic        cfg_sel = 1'b0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_tag = '0;
    logic [1:0]  req_acc = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_ok;
    logic        rsp_hit;
    logic [2:0]  rsp_rgn;
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic [1:0]  fault_acc;
    logic [2:0]  fault_tag;
    logic        fault_clr = 1'b0;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    hs32_mpu_pipe dut (
        .clk(clk), .rstn(rstn),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_tag(req_tag), .req_acc(req_acc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok),
        .rsp_hit(rsp_hit), .rsp_rgn(rsp_rgn),
        .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_acc(fault_acc),
        .fault_tag(fault_tag), .fault_clr(fault_clr)
    );

    task automatic cfg_write(input logic [2:0] idx, input logic sel, input logic [31:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        $display("cfg write idx=%0d sel=%0d data=%08h", idx, sel, data);
    endtask

    task automatic cfg_read(input logic [2:0] idx, input logic sel, output logic [31:0] data);
        @(negedge clk);
        cfg_idx = idx; cfg_sel = sel;
        #1;
        data = cfg_rdata;
        $display("cfg read  idx=%0d sel=%0d data=%08h", idx, sel, data);
    endtask

    // One request with rsp_ready high; returns 1 ns after the accepting edge
    task automatic do_req(input logic [31:0] addr, input logic [1:0] acc,
                          input logic [2:0] tag, input logic clr);
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; req_acc = acc; req_tag = tag; fault_clr = clr;
        @(posedge clk);
        #1;
        req_valid = 1'b0; fault_clr = 1'b0;
        $display("req addr=%08h acc=%0d tag=%0d -> valid=%b hit=%b rgn=%0d ok=%b fault=%b@%08h",
                 addr, acc, tag, rsp_valid, rsp_hit, rsp_rgn, rsp_ok, fault_valid, fault_addr);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
        vecs++; if (fault_valid !== 1'b0) begin errs++; $display("FAIL clr_valid: got %b want 0", fault_valid); end
    endtask

    task automatic test_reset();
        #3;
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        vecs++; if (fault_valid !== 1'b0) begin errs++; $display("FAIL rst_fault_valid: got %b want 0", fault_valid); end
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_no_config();
        do_req(32'h1000, 2'b00, 3'd0, 1'b0);
        vecs++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL t1_valid: got %b want 1", rsp_valid); end
        vecs++; if (rsp_hit !== 1'b0) begin errs++; $display("FAIL t1_hit: got %b want 0", rsp_hit); end
        vecs++; if (rsp_ok !== 1'b0) begin errs++; $display("FAIL t1_ok: got %b want 0", rsp_ok); end
        vecs++; if (fault_valid !== 1'b1) begin errs++; $display("FAIL t1_fvalid: got %b want 1", fault_valid); end
        vecs++; if (fault_addr !== 32'h1000) begin errs++; $display("FAIL t1_faddr: got %h want 00001000", fault_addr); end
        pulse_clr();
    endtask

    task automatic test_basic_region();
        logic [31:0] rd;
        cfg_write(3'd0, 1'b0, 32'h0000_8000);
        cfg_write(3'd0, 1'b1, 32'h00FF_0305);
        cfg_read(3'd0, 1'b1, rd);
        vecs++; if (rd !== 32'h00FF_0305) begin errs++; $display("FAIL t2_attr_rd: got %h want 00ff0305", rd); end
        cfg_read(3'd0, 1'b0, rd);
        vecs++; if (rd !== 32'h0000_8000) begin errs++; $display("FAIL t2_base_rd: got %h want 00008000", rd); end
        do_req(32'h8ABC, 2'b01, 3'd0, 1'b0);
        vecs++; if (rsp_hit !== 1'b1 || rsp_ok !== 1'b0) begin errs++; $display("FAIL t2_w: got hit=%b ok=%b want hit=1 ok=0", rsp_hit, rsp_ok); end
        vecs++; if (fault_addr !== 32'h8ABC || fault_acc !== 2'b01) begin errs++; $display("FAIL t2_fault: got %h/%0d want 00008abc/1", fault_addr, fault_acc); end
        do_req(32'h8ABC, 2'b00, 3'd0, 1'b0);
        vecs++; if (rsp_ok !== 1'b1 || rsp_rgn !== 3'd0) begin errs++; $display("FAIL t2_r: got ok=%b rgn=%0d want ok=1 rgn=0", rsp_ok, rsp_rgn); end
    endtask

    task automatic test_subregion();
        cfg_write(3'd0, 1'b1, 32'h00DF_0305);
        do_req(32'h8A00, 2'b00, 3'd0, 1'b0);
        vecs++; if (rsp_hit !== 1'b0 || rsp_ok !== 1'b0) begin errs++; $display("FAIL t3_sub5: got hit=%b ok=%b want hit=0 ok=0", rsp_hit, rsp_ok); end
        do_req(32'h89FC, 2'b00, 3'd0, 1'b0);
        vecs++; if (rsp_hit !== 1'b1 || rsp_ok !== 1'b1) begin errs++; $display("FAIL t3_sub4: got hit=%b ok=%b want hit=1 ok=1", rsp_hit, rsp_ok); end
    endtask

    task automatic test_priority();
        logic [31:0] rd;
        cfg_write(3'd1, 1'b0, 32'h0000_8000);
        cfg_write(3'd1, 1'b1, 32'h00FF_041D);
        do_req(32'h8004, 2'b01, 3'd0, 1'b0);
        vecs++; if (rsp_rgn !== 3'd0 || rsp_ok !== 1'b0 || rsp_hit !== 1'b1) begin errs++; $display("FAIL t4_overlap: got rgn=%0d ok=%b hit=%b want 0/0/1", rsp_rgn, rsp_ok, rsp_hit); end
        do_req(32'h8A00, 2'b01, 3'd0, 1'b0);
        vecs++; if (rsp_rgn !== 3'd1 || rsp_ok !== 1'b1) begin errs++; $display("FAIL t4_fallthru: got rgn=%0d ok=%b want 1/1", rsp_rgn, rsp_ok); end
        do_req(32'h8A00, 2'b11, 3'd0, 1'b0);
        vecs++; if (rsp_rgn !== 3'd1 || rsp_ok !== 1'b0) begin errs++; $display("FAIL t4_acc11: got rgn=%0d ok=%b want 1/0", rsp_rgn, rsp_ok); end
        do_req(32'h8004, 2'b00, 3'd1, 1'b0);
        vecs++; if (rsp_hit !== 1'b0 || rsp_rgn !== 3'd0) begin errs++; $display("FAIL t4_tagmiss: got hit=%b rgn=%0d want 0/0", rsp_hit, rsp_rgn); end
        cfg_write(3'd2, 1'b1, 32'hFBFF_0085);
        cfg_read(3'd2, 1'b1, rd);
        vecs++; if (rd !== 32'h03FF_0145) begin errs++; $display("FAIL t4_clamp_rd: got %h want 03ff0145", rd); end
    endtask

    task automatic test_lock();
        logic [31:0] rd;
        cfg_write(3'd0, 1'b1, 32'h00DF_0307);
        cfg_write(3'd0, 1'b1, 32'h0000_0000);
        cfg_write(3'd0, 1'b0, 32'h0000_0000);
        cfg_read(3'd0, 1'b1, rd);
        vecs++; if (rd !== 32'h00DF_0307) begin errs++; $display("FAIL t5_lock_attr: got %h want 00df0307", rd); end
        cfg_read(3'd0, 1'b0, rd);
        vecs++; if (rd !== 32'h0000_8000) begin errs++; $display("FAIL t5_lock_base: got %h want 00008000", rd); end
        do_req(32'h89FC, 2'b00, 3'd0, 1'b0);
        vecs++; if (rsp_rgn !== 3'd0 || rsp_ok !== 1'b1) begin errs++; $display("FAIL t5_lock_lookup: got rgn=%0d ok=%b want 0/1", rsp_rgn, rsp_ok); end
        do_req(32'h9000, 2'b00, 3'd0, 1'b0);
        vecs++; if (rsp_valid !== 1'b1 || fault_valid !== 1'b1) begin errs++; $display("FAIL t5_pre_rst: got valid=%b fault=%b want 1/1", rsp_valid, fault_valid); end
        #2;
        rstn = 1'b0;
        #1;
        vecs++; if (rsp_valid !== 1'b0 || fault_valid !== 1'b0 || fault_addr !== 32'h0) begin errs++; $display("FAIL t5_async_rst: got valid=%b fault=%b addr=%h want 0/0/0", rsp_valid, fault_valid, fault_addr); end
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cfg_read(3'd0, 1'b1, rd);
        vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL t5_unlock_attr: got %h want 00000000", rd); end
        do_req(32'h89FC, 2'b00, 3'd0, 1'b0);
        vecs++; if (rsp_hit !== 1'b0) begin errs++; $display("FAIL t5_post_rst_hit: got %b want 0", rsp_hit); end
        pulse_clr();
    endtask

    task automatic test_back_to_back();
        cfg_write(3'd0, 1'b0, 32'h0000_8000);
        cfg_write(3'd0, 1'b1, 32'h00FF_0305);
        pulse_clr();
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h8010; req_acc = 2'b00; req_tag = 3'd0;
        @(posedge clk);
        #1;
        vecs++; if (rsp_valid !== 1'b1 || rsp_ok !== 1'b1) begin errs++; $display("FAIL t6_a: got valid=%b ok=%b want 1/1", rsp_valid, rsp_ok); end
        @(negedge clk);
        req_acc = 2'b01;
        #1;
        vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL t6_stall_ready: got %b want 0", req_ready); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            vecs++; if (rsp_valid !== 1'b1 || rsp_ok !== 1'b1 || req_ready !== 1'b0) begin errs++; $display("FAIL t6_hold%0d: got valid=%b ok=%b ready=%b want 1/1/0", c, rsp_valid, rsp_ok, req_ready); end
            $display("stall cycle %0d valid=%b ok=%b ready=%b", c, rsp_valid, rsp_ok, req_ready);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL t6_release_ready: got %b want 1", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        vecs++; if (rsp_valid !== 1'b1 || rsp_ok !== 1'b0 || rsp_hit !== 1'b1) begin errs++; $display("FAIL t6_b: got valid=%b ok=%b hit=%b want 1/0/1", rsp_valid, rsp_ok, rsp_hit); end
        vecs++; if (fault_addr !== 32'h8010 || fault_acc !== 2'b01) begin errs++; $display("FAIL t6_fault1: got %h/%0d want 00008010/1", fault_addr, fault_acc); end
        do_req(32'h9000, 2'b01, 3'd1, 1'b0);
        vecs++; if (fault_valid !== 1'b1 || fault_addr !== 32'h8010 || fault_tag !== 3'd0) begin errs++; $display("FAIL t6_fault2_drop: got %b %h tag=%0d want 1 00008010 tag=0", fault_valid, fault_addr, fault_tag); end
        do_req(32'hA000, 2'b10, 3'd2, 1'b1);
        vecs++; if (fault_valid !== 1'b1 || fault_addr !== 32'hA000 || fault_acc !== 2'b10 || fault_tag !== 3'd2) begin errs++; $display("FAIL t6_fault3_clr: got %b %h acc=%0d tag=%0d want 1 0000a000 acc=2 tag=2", fault_valid, fault_addr, fault_acc, fault_tag); end
        @(posedge clk);
        #1;
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL t6_drain: got %b want 0", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_no_config();
        test_basic_region();
        test_subregion();
        test_priority();
        test_lock();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
